pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
Next-generation program-counter unit for the pipelined core. It holds the fetch PC and predicts taken control transfers with a parametrised direct-mapped branch target buffer (BTB). It resolves branch, JAL and JALR targets from execute-stage operands and redirects fetch on a misprediction. It replaces the single-cycle branch-target adder by adding state, prediction, stall handling and misalignment detection.

Parameters:
ADDR_WIDTH, 32, width of the PC and of every target
DATA_WIDTH, 32, width of immOp and result
BTB_ENTRIES, 16, number of BTB entries; must be a power of 2 and at least 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  core clock, rising-edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold pcF; a redirect overrides it
pcF  output  ADDR_WIDTH  current fetch PC (registered)
predTakenF  output  1  BTB hit at pcF
predTargetF  output  ADDR_WIDTH  BTB target at pcF; 0 when there is no hit
resolveValid  input  1  execute stage holds a branch, JAL or JALR this cycle
pcE  input  ADDR_WIDTH  PC of the resolving instruction
immOp  input  DATA_WIDTH  sign-extended immediate of the resolving instruction
result  input  DATA_WIDTH  ALU rs1+imm, used for JALR
jalrSrc  input  1  the resolving instruction is JALR
takenE  input  1  actual branch outcome; 1 for JAL and JALR
predTakenE  input  1  prediction piped down with the instruction
predTargetE  input  ADDR_WIDTH  predicted target piped down with the instruction
mispredict  output  1  combinational; flush F/D and redirect
misalign  output  1  registered one-cycle pulse: the taken target was not word-aligned

Behaviour:
- Target computation:
  - tgtE = jalrSrc ? {result[ADDR_WIDTH-1:1],1'b0} : pcE + immOp, modulo 2^ADDR_WIDTH (wrap silently).
  - When DATA_WIDTH differs from ADDR_WIDTH, truncate or zero-extend to ADDR_WIDTH.
- Corrected PC: corrPC = takenE ? tgtE : pcE + 4.
- mispredict = resolveValid & ((takenE != predTakenE) | (takenE & predTakenE & (tgtE != predTargetE))).
- BTB:
  - IDX = log2(BTB_ENTRIES).
  - Index = pc[IDX+1:2]; tag = pc[ADDR_WIDTH-1:IDX+2].
  - Each entry holds valid, tag and target.
  - Lookup is combinational on pcF. Hit = valid & tag match.
- PC register, evaluated at each rising edge in priority order:
  1. mispredict → pcF <= corrPC, regardless of stall.
  2. stall → pcF holds.
  3. predTakenF → pcF <= predTargetF.
  4. Otherwise → pcF <= pcF + 4, wrapping at 2^ADDR_WIDTH.
- BTB update at the clock edge when resolveValid; stall does not block it:
  - takenE=1 → write entry[index(pcE)] = {1, tag(pcE), tgtE}. This overwrites any alias.
  - takenE=0 and the entry's tag matches pcE → clear its valid bit.
  - takenE=0 and the tag does not match → no change.
- Same-cycle lookup and update on the same index: the lookup sees the old contents; the new contents are visible from the next cycle.
- misalign <= resolveValid & takenE & (tgtE[1] | tgtE[0]).
  - The redirect still occurs.
  - misalign is cleared in every cycle without that condition.
- Latency:
  - Redirect is visible on pcF one cycle after mispredict.
  - A BTB-predicted target is visible on pcF one cycle after the hit.
- Reset (asynchronous, at any time including mid-redirect):
  - pcF = RESET_PC.
  - All BTB valid bits = 0, so predTakenF = 0 and predTargetF = 0.
  - misalign = 0.
  - Tag and target storage need not be reset.

Test Plan:
- Reset with RESET_PC=0x100, then 3 free-running cycles → pcF = 0x100, 0x104, 0x108, 0x10C; predTakenF=0 throughout.
- Branch at pcE=0x104, immOp=-8, takenE=1, predTakenE=0 → mispredict=1, next pcF=0xFC, BTB[1] written; when fetch reaches 0x104 again → predTakenF=1, predTargetF=0xFC, next pcF=0xFC.
- JALR with result=0x2003, predTakenE=1, predTargetE=0x2000 → tgtE=0x2002, mispredict=1, misalign pulses for one cycle, pcF=0x2002.
- Predicted taken but takenE=0 at pcE=0x104 → mispredict=1, pcF=0x108, BTB entry for 0x104 invalidated; an aliasing PC 0x144 (16 entries) with a different tag leaves the entry intact.
- stall=1 held for 3 cycles → pcF constant; a mispredict during the stall still loads corrPC on the next edge.
- Assert rst while a mispredict is pending → pcF returns to RESET_PC immediately, all predictions cleared, misalign=0.

Source files
------------

// File: rtl/pc_next_unit_if.sv
// Fetch/resolve bus of the PC unit: the pipeline (master) drives stall and the
// execute-stage resolution; the PC unit (slave) returns the fetch PC, prediction and redirect.
interface pc_next_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic [ADDR_WIDTH-1:0] pcF;
  logic                  predTakenF;
  logic [ADDR_WIDTH-1:0] predTargetF;
  logic                  resolveValid;
  logic [ADDR_WIDTH-1:0] pcE;
  logic [DATA_WIDTH-1:0] immOp;
  logic [DATA_WIDTH-1:0] result;
  logic                  jalrSrc;
  logic                  takenE;
  logic                  predTakenE;
  logic [ADDR_WIDTH-1:0] predTargetE;
  logic                  mispredict;
  logic                  misalign;

  modport master (
    output stall, resolveValid, pcE, immOp, result, jalrSrc, takenE, predTakenE, predTargetE,
    input  pcF, predTakenF, predTargetF, mispredict, misalign
  );

  modport slave (
    input  stall, resolveValid, pcE, immOp, result, jalrSrc, takenE, predTakenE, predTargetE,
    output pcF, predTakenF, predTargetF, mispredict, misalign
  );
endinterface

// File: rtl/pc_next_unit.sv
// Fetch PC register with a direct-mapped BTB predictor; resolves branch/JAL/JALR
// targets from execute-stage operands and redirects fetch on a misprediction.
module pc_next_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst,
  pc_next_unit_if.slave      bus
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   misalign_q, misalign_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0]  tgt_q [BTB_ENTRIES];

  logic [ADDR_WIDTH-1:0]  imm_a, res_a, tgt_e, corr_pc;
  logic [IDX-1:0]         f_idx, e_idx;
  logic [TAG_W-1:0]       f_tag, e_tag;
  logic                   f_hit, e_tag_match, mispredict;

  // Operand width adaptation: truncate wider data, zero-extend narrower data.
  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_trunc
      assign imm_a = bus.immOp[ADDR_WIDTH-1:0];
      assign res_a = bus.result[ADDR_WIDTH-1:0];
      if (DATA_WIDTH > ADDR_WIDTH) begin : g_drop
        logic unused_hi;
        assign unused_hi = ^{bus.immOp[DATA_WIDTH-1:ADDR_WIDTH],
                             bus.result[DATA_WIDTH-1:ADDR_WIDTH]};
      end
    end else begin : g_zext
      assign imm_a = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, bus.immOp};
      assign res_a = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, bus.result};
    end
  endgenerate

  logic unused_res0;
  assign unused_res0 = res_a[0];

  assign tgt_e   = bus.jalrSrc ? {res_a[ADDR_WIDTH-1:1], 1'b0} : bus.pcE + imm_a;
  assign corr_pc = bus.takenE ? tgt_e : bus.pcE + ADDR_WIDTH'(4);

  assign mispredict = bus.resolveValid &
                      ((bus.takenE != bus.predTakenE) |
                       (bus.takenE & bus.predTakenE & (tgt_e != bus.predTargetE)));

  // Fetch-side lookup reads the pre-update contents.
  assign f_idx = pc_q[IDX+1:2];
  assign f_tag = pc_q[ADDR_WIDTH-1:IDX+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign e_idx       = bus.pcE[IDX+1:2];
  assign e_tag       = bus.pcE[ADDR_WIDTH-1:IDX+2];
  assign e_tag_match = (tag_q[e_idx] == e_tag);

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_valid
      always_comb begin
        valid_d[gi] = valid_q[gi];
        if (bus.resolveValid && (e_idx == IDX'(gi))) begin
          if (bus.takenE)
            valid_d[gi] = 1'b1;
          else if (e_tag_match)
            valid_d[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(4);
    if (mispredict)
      pc_d = corr_pc;
    else if (bus.stall)
      pc_d = pc_q;
    else if (f_hit)
      pc_d = tgt_q[f_idx];
  end

  assign misalign_d = bus.resolveValid & bus.takenE & (tgt_e[1] | tgt_e[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      valid_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Tag/target storage carries no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (bus.resolveValid && bus.takenE) begin
      tag_q[e_idx] <= e_tag;
      tgt_q[e_idx] <= tgt_e;
    end
  end

  assign bus.pcF         = pc_q;
  assign bus.predTakenF  = f_hit;
  assign bus.predTargetF = f_hit ? tgt_q[f_idx] : '0;
  assign bus.mispredict  = mispredict;
  assign bus.misalign    = misalign_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed vector bench for pc_next_unit: a table of per-cycle stimulus with
// expected fetch-side outputs, plus a hand-written asynchronous reset sequence.
module tb_pc_next_unit;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  pc_next_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  pc_next_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BTB_ENTRIES(16),
    .RESET_PC   (32'h100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] pc_e;
    logic [31:0] imm;
    logic [31:0] res;
    logic        jalr;
    logic        taken;
    logic        pt_e;
    logic [31:0] ptg_e;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mp;
    logic        e_ma;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic rv, logic [31:0] pc_e, logic [31:0] imm,
                              logic [31:0] res, logic jalr, logic taken, logic pt_e,
                              logic [31:0] ptg_e, logic [31:0] e_pc, logic e_pt,
                              logic [31:0] e_ptg, logic e_mp, logic e_ma);
    vec_t v;
    v.stall = st;   v.rv = rv;       v.pc_e = pc_e;   v.imm = imm;   v.res = res;
    v.jalr = jalr;  v.taken = taken; v.pt_e = pt_e;   v.ptg_e = ptg_e;
    v.e_pc = e_pc;  v.e_pt = e_pt;   v.e_ptg = e_ptg; v.e_mp = e_mp; v.e_ma = e_ma;
    return v;
  endfunction

  // Idle cycle: only the expected fetch-side state.
  function automatic vec_t idle(logic st, logic [31:0] e_pc, logic e_pt,
                                logic [31:0] e_ptg, logic e_ma);
    return mk(st, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              e_pc, e_pt, e_ptg, 1'b0, e_ma);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.stall        = v.stall;
    bus.resolveValid = v.rv;
    bus.pcE          = v.pc_e;
    bus.immOp        = v.imm;
    bus.result       = v.res;
    bus.jalrSrc      = v.jalr;
    bus.takenE       = v.taken;
    bus.predTakenE   = v.pt_e;
    bus.predTargetE  = v.ptg_e;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    drive(idle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0));

    //               st  rv  pcE           imm           res       jalr tk  ptE ptgE      pcF       pt  ptg       mp  ma
    vecs.push_back(idle(0, 32'h100, 0, 32'h0, 0));
    vecs.push_back(idle(0, 32'h104, 0, 32'h0, 0));
    vecs.push_back(idle(0, 32'h108, 0, 32'h0, 0));
    vecs.push_back(idle(0, 32'h10C, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h104,      32'hFFFFFFF8, 32'h0,    0, 1, 0, 32'h0,    32'h110,  0, 32'h0,   1, 0));
    vecs.push_back(idle(0, 32'h0FC, 0, 32'h0, 0));
    vecs.push_back(idle(0, 32'h100, 0, 32'h0, 0));
    vecs.push_back(idle(0, 32'h104, 1, 32'hFC, 0));
    vecs.push_back(mk(0, 1, 32'h200,      32'h0,        32'h2003, 1, 1, 1, 32'h2000, 32'h0FC,  0, 32'h0,   1, 0));
    vecs.push_back(idle(0, 32'h2002, 0, 32'h0, 1));
    vecs.push_back(mk(0, 1, 32'h144,      32'h8,        32'h0,    0, 0, 0, 32'h0,    32'h2006, 0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 32'h100,      32'h4,        32'h0,    0, 1, 0, 32'h0,    32'h200A, 0, 32'h0,   1, 0));
    vecs.push_back(mk(0, 1, 32'h104,      32'h8,        32'h0,    0, 0, 1, 32'hFC,   32'h104,  1, 32'hFC,  1, 0));
    vecs.push_back(idle(0, 32'h108, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h100,      32'h4,        32'h0,    0, 1, 0, 32'h0,    32'h10C,  0, 32'h0,   1, 0));
    vecs.push_back(idle(0, 32'h104, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h100,      32'h4,        32'h0,    0, 1, 1, 32'h104,  32'h108,  0, 32'h0,   0, 0));
    vecs.push_back(idle(1, 32'h10C, 0, 32'h0, 0));
    vecs.push_back(idle(1, 32'h10C, 0, 32'h0, 0));
    vecs.push_back(idle(1, 32'h10C, 0, 32'h0, 0));
    vecs.push_back(mk(1, 1, 32'h300,      32'h10,       32'h0,    0, 1, 0, 32'h0,    32'h10C,  0, 32'h0,   1, 0));
    vecs.push_back(idle(0, 32'h310, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h2F0,      32'h10,       32'h0,    0, 1, 0, 32'h0,    32'h314,  0, 32'h0,   1, 0));
    vecs.push_back(idle(1, 32'h300, 1, 32'h310, 0));
    vecs.push_back(idle(0, 32'h300, 1, 32'h310, 0));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 32'h8,        32'h0,    0, 1, 1, 32'h0,    32'h310,  0, 32'h0,   1, 0));
    vecs.push_back(mk(0, 1, 32'h400,      32'h2,        32'h0,    0, 1, 0, 32'h0,    32'h004,  0, 32'h0,   1, 0));
    vecs.push_back(idle(0, 32'h402, 1, 32'h402, 1));
    vecs.push_back(idle(0, 32'h402, 1, 32'h402, 0));

    repeat (2) @(negedge clk);
    check("reset_pcF", bus.pcF, 32'h100);
    check("reset_predTakenF", {31'b0, bus.predTakenF}, 32'h0);
    check("reset_predTargetF", bus.predTargetF, 32'h0);
    check("reset_misalign", {31'b0, bus.misalign}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_pcF", i), bus.pcF, vecs[i].e_pc);
      check($sformatf("v%0d_predTakenF", i), {31'b0, bus.predTakenF}, {31'b0, vecs[i].e_pt});
      check($sformatf("v%0d_predTargetF", i), bus.predTargetF, vecs[i].e_ptg);
      check($sformatf("v%0d_mispredict", i), {31'b0, bus.mispredict}, {31'b0, vecs[i].e_mp});
      check($sformatf("v%0d_misalign", i), {31'b0, bus.misalign}, {31'b0, vecs[i].e_ma});
      $display("vec %0d: stall=%0b rv=%0b pcE=%08h pcF=%08h predTakenF=%0b predTargetF=%08h mispredict=%0b misalign=%0b",
               i, vecs[i].stall, vecs[i].rv, vecs[i].pc_e, bus.pcF, bus.predTakenF,
               bus.predTargetF, bus.mispredict, bus.misalign);
      @(negedge clk);
    end

    // Reset arriving mid-redirect, with misalign high and a BTB entry valid for RESET_PC.
    drive(mk(0, 1, 32'h100, 32'h21, 32'h0, 0, 1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    #1;
    check("rs_first_mispredict", {31'b0, bus.mispredict}, 32'h1);
    @(negedge clk);
    drive(mk(0, 1, 32'h600, 32'h40, 32'h0, 0, 1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    #1;
    check("rs_pre_pcF", bus.pcF, 32'h121);
    check("rs_pre_misalign", {31'b0, bus.misalign}, 32'h1);
    check("rs_pending_mispredict", {31'b0, bus.mispredict}, 32'h1);
    $display("rst seq: pcF=%08h misalign=%0b mispredict=%0b before reset", bus.pcF, bus.misalign, bus.mispredict);
    rst = 1'b1;
    #1;
    check("rs_async_pcF", bus.pcF, 32'h100);
    check("rs_async_misalign", {31'b0, bus.misalign}, 32'h0);
    check("rs_async_predTakenF", {31'b0, bus.predTakenF}, 32'h0);
    check("rs_async_predTargetF", bus.predTargetF, 32'h0);
    $display("rst seq: pcF=%08h misalign=%0b predTakenF=%0b during reset", bus.pcF, bus.misalign, bus.predTakenF);
    @(posedge clk);
    #1;
    check("rs_hold_pcF", bus.pcF, 32'h100);
    @(negedge clk);
    drive(idle(0, 32'h0, 0, 32'h0, 0));
    rst = 1'b0;
    #1;
    check("rs_post_pcF", bus.pcF, 32'h100);
    check("rs_post_predTakenF", {31'b0, bus.predTakenF}, 32'h0);
    check("rs_post_predTargetF", bus.predTargetF, 32'h0);
    @(negedge clk);
    #1;
    check("rs_run_pcF", bus.pcF, 32'h104);
    $display("rst seq: pcF=%08h predTakenF=%0b after release", bus.pcF, bus.predTakenF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
